// File: rtl/segment_scan_ctrl.sv
// segment_scan_ctrl: time-multiplexed scan controller for a bank of
// seven-segment digits that share one segment_static decoder.
// Ports: clk, rst_n (sync, active-low), run, load, digits_in, en_mask ->
//   data_out (decoder input), dig_en (one-hot), seg_blank, load_ack,
//   frame_done. All outputs are registered.
module segment_scan_ctrl #(
   parameter int N_DIGITS  = 4,
   parameter int SCAN_DIV  = 1000,
   parameter int BLANK_CYC = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  run,
   input  logic                  load,
   input  logic [4*N_DIGITS-1:0] digits_in,
   input  logic [N_DIGITS-1:0]   en_mask,
   output logic [3:0]            data_out,
   output logic [N_DIGITS-1:0]   dig_en,
   output logic                  seg_blank,
   output logic                  load_ack,
   output logic                  frame_done
);

   localparam int IW   = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
   localparam int MAXC = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
   localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

   localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
   localparam logic [CW-1:0] SHOW_LAST  = CW'(SCAN_DIV - 1);
   localparam logic [IW-1:0] IDX_LAST   = IW'(N_DIGITS - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BLANK = 2'd1,
      SHOW  = 2'd2
   } state_t;

   state_t      state;
   state_t      st_n;
   logic [IW-1:0] idx;
   logic [IW-1:0] idx_n;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_n;
   logic          pending;
   logic          frame_end;
   logic          commit;
   logic          lit;

   logic [3:0] shadow [N_DIGITS];
   logic [3:0] active [N_DIGITS];
   logic [3:0] act_n  [N_DIGITS];

   // Next-state logic; run=0 forces IDLE from any state.
   always_comb begin
      st_n      = state;
      idx_n     = idx;
      cnt_n     = cnt;
      frame_end = 1'b0;
      if (!run) begin
         st_n  = IDLE;
         idx_n = '0;
         cnt_n = '0;
      end else begin
         unique case (state)
            IDLE: begin
               st_n  = BLANK;
               idx_n = '0;
               cnt_n = '0;
            end
            BLANK: begin
               if (cnt == BLANK_LAST) begin
                  st_n  = SHOW;
                  cnt_n = '0;
               end else begin
                  cnt_n = cnt + 1'b1;
               end
            end
            SHOW: begin
               if (cnt == SHOW_LAST) begin
                  st_n      = BLANK;
                  cnt_n     = '0;
                  frame_end = (idx == IDX_LAST);
                  idx_n     = (idx == IDX_LAST) ? '0 : idx + 1'b1;
               end else begin
                  cnt_n = cnt + 1'b1;
               end
            end
            default: begin
               st_n  = IDLE;
               idx_n = '0;
               cnt_n = '0;
            end
         endcase
      end
   end

   // Commit the shadow only at a frame boundary, or at once when idle.
   assign commit = pending && (frame_end || state == IDLE);
   assign lit    = (st_n == SHOW) && en_mask[idx_n];

   always_comb begin
      for (int i = 0; i < N_DIGITS; i++) begin
         act_n[i] = commit ? shadow[i] : active[i];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         idx        <= '0;
         cnt        <= '0;
         pending    <= 1'b0;
         data_out   <= 4'h0;
         dig_en     <= '0;
         seg_blank  <= 1'b1;
         load_ack   <= 1'b0;
         frame_done <= 1'b0;
         for (int i = 0; i < N_DIGITS; i++) begin
            shadow[i] <= 4'h0;
            active[i] <= 4'h0;
         end
      end else begin
         state <= st_n;
         idx   <= idx_n;
         cnt   <= cnt_n;
         // A load on the commit edge stays pending for the next frame.
         if (commit) begin
            pending <= load;
         end else if (load) begin
            pending <= 1'b1;
         end
         for (int i = 0; i < N_DIGITS; i++) begin
            if (load) begin
               shadow[i] <= digits_in[4*i +: 4];
            end
            active[i] <= act_n[i];
         end
         // Outputs reflect the state being entered on this edge.
         data_out   <= (st_n == IDLE) ? 4'h0 : act_n[idx_n];
         dig_en     <= lit ? ({{(N_DIGITS-1){1'b0}}, 1'b1} << idx_n) : '0;
         seg_blank  <= ~lit;
         load_ack   <= commit;
         frame_done <= frame_end;
      end
   end

endmodule

// File: tb/tb_segment_scan_ctrl.sv
// tb_segment_scan_ctrl: scoreboard bench for segment_scan_ctrl with
// N_DIGITS=4, SCAN_DIV=8, BLANK_CYC=2; per-cycle expected output queue.
module tb_segment_scan_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        run;
   logic        load;
   logic [15:0] digits_in;
   logic [3:0]  en_mask;
   logic [3:0]  data_out;
   logic [3:0]  dig_en;
   logic        seg_blank;
   logic        load_ack;
   logic        frame_done;

   int errors = 0;
   int checks = 0;

   // Expected entry: {dig_en, seg_blank, data_out, frame_done, load_ack}
   logic [10:0] q[$];
   logic [10:0] exp_v;
   logic [10:0] got_v;

   segment_scan_ctrl #(
      .N_DIGITS (4),
      .SCAN_DIV (8),
      .BLANK_CYC(2)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .run       (run),
      .load      (load),
      .digits_in (digits_in),
      .en_mask   (en_mask),
      .data_out  (data_out),
      .dig_en    (dig_en),
      .seg_blank (seg_blank),
      .load_ack  (load_ack),
      .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   function automatic logic [10:0] ent(input logic [3:0] de, input logic sb,
                                       input logic [3:0] d, input logic fd,
                                       input logic ack);
      return {de, sb, d, fd, ack};
   endfunction

   function automatic logic [10:0] obs();
      return {dig_en, seg_blank, data_out, frame_done, load_ack};
   endfunction

   function automatic void push_idle(input int n, input logic ack);
      for (int i = 0; i < n; i++) q.push_back(ent(4'h0, 1'b1, 4'h0, 1'b0, ack));
   endfunction

   // One frame: per digit 2 blank cycles then 8 show cycles.
   function automatic void push_frame(input logic [15:0] v, input logic [3:0] m,
                                      input logic fd, input logic ack);
      logic [3:0] dd;
      logic [3:0] oh;
      for (int d = 0; d < 4; d++) begin
         dd = v[4*d +: 4];
         oh = 4'b0001 << d;
         for (int c = 0; c < 10; c++) begin
            if (c < 2)
               q.push_back(ent(4'h0, 1'b1, dd, (d == 0 && c == 0) ? fd : 1'b0,
                               (d == 0 && c == 0) ? ack : 1'b0));
            else if (m[d])
               q.push_back(ent(oh, 1'b0, dd, 1'b0, 1'b0));
            else
               q.push_back(ent(4'h0, 1'b1, dd, 1'b0, 1'b0));
         end
      end
   endfunction

   task automatic test_reset();
      rst_n = 1'b0; run = 1'b0; load = 1'b0;
      digits_in = 16'h0; en_mask = 4'hF;
      push_idle(3, 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         exp_v = q.pop_front(); got_v = obs(); checks++;
         if (got_v !== exp_v) begin
            errors++;
            $display("FAIL reset cyc %0d got %h exp %h", i, got_v, exp_v);
         end
      end
      rst_n = 1'b1;
      push_idle(50, 1'b0);
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         exp_v = q.pop_front(); got_v = obs(); checks++;
         if (got_v !== exp_v) begin
            errors++;
            $display("FAIL idle cyc %0d got %h exp %h", i, got_v, exp_v);
         end
      end
   endtask

   task automatic test_idle_load();
      load = 1'b1; digits_in = 16'h4321;
      push_idle(1, 1'b0);
      push_idle(1, 1'b1);
      push_idle(2, 1'b0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         load = 1'b0;
         exp_v = q.pop_front(); got_v = obs(); checks++;
         if (got_v !== exp_v) begin
            errors++;
            $display("FAIL idle_load cyc %0d got %h exp %h", i, got_v, exp_v);
         end
      end
   endtask

   task automatic test_basic_scan();
      run = 1'b1; en_mask = 4'hF;
      push_frame(16'h4321, 4'hF, 1'b0, 1'b0);
      push_frame(16'h4321, 4'hF, 1'b1, 1'b0);
      push_frame(16'h4321, 4'hF, 1'b1, 1'b0);
      for (int i = 0; i < 120; i++) begin
         @(negedge clk);
         exp_v = q.pop_front(); got_v = obs(); checks++;
         if (got_v !== exp_v) begin
            errors++;
            $display("FAIL basic cyc %0d got %h exp %h", i, got_v, exp_v);
         end
      end
   endtask

   task automatic test_tear_free();
      push_frame(16'h4321, 4'hF, 1'b1, 1'b0);
      push_frame(16'hABCD, 4'hF, 1'b1, 1'b1);
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         load = 1'b0;
         exp_v = q.pop_front(); got_v = obs(); checks++;
         if (got_v !== exp_v) begin
            errors++;
            $display("FAIL tear_free cyc %0d got %h exp %h", i, got_v, exp_v);
         end
         if (i == 12) begin
            load = 1'b1; digits_in = 16'hABCD;
         end
      end
   endtask

   task automatic test_mask_overwrite();
      en_mask = 4'b0101;
      push_frame(16'hABCD, 4'b0101, 1'b1, 1'b0);
      push_frame(16'h2222, 4'b0101, 1'b1, 1'b1);
      push_frame(16'h2222, 4'b0101, 1'b1, 1'b0);
      for (int i = 0; i < 120; i++) begin
         @(negedge clk);
         load = 1'b0;
         exp_v = q.pop_front(); got_v = obs(); checks++;
         if (got_v !== exp_v) begin
            errors++;
            $display("FAIL mask_ovw cyc %0d got %h exp %h", i, got_v, exp_v);
         end
         if (i == 5) begin
            load = 1'b1; digits_in = 16'h1111;
         end
         if (i == 25) begin
            load = 1'b1; digits_in = 16'h2222;
         end
      end
   endtask

   task automatic test_run_drop_reset();
      en_mask = 4'hF;
      push_frame(16'h2222, 4'hF, 1'b1, 1'b0);
      repeat (15) void'(q.pop_back());
      push_idle(3, 1'b0);
      push_frame(16'h2222, 4'hF, 1'b0, 1'b0);
      repeat (24) void'(q.pop_back());
      push_idle(2, 1'b0);
      push_frame(16'h0000, 4'hF, 1'b0, 1'b0);
      for (int i = 0; i < 86; i++) begin
         @(negedge clk);
         exp_v = q.pop_front(); got_v = obs(); checks++;
         if (got_v !== exp_v) begin
            errors++;
            $display("FAIL run_drop cyc %0d got %h exp %h", i, got_v, exp_v);
         end
         if (i == 24) run = 1'b0;
         if (i == 27) run = 1'b1;
         if (i == 43) rst_n = 1'b0;
         if (i == 45) rst_n = 1'b1;
      end
   endtask

   task automatic test_boundary();
      push_frame(16'h0000, 4'hF, 1'b1, 1'b0);
      push_frame(16'h5555, 4'hF, 1'b1, 1'b1);
      push_frame(16'h6789, 4'hF, 1'b1, 1'b1);
      push_frame(16'h6789, 4'hF, 1'b1, 1'b0);
      for (int i = 0; i < 160; i++) begin
         @(negedge clk);
         load = 1'b0;
         exp_v = q.pop_front(); got_v = obs(); checks++;
         if (got_v !== exp_v) begin
            errors++;
            $display("FAIL boundary cyc %0d got %h exp %h", i, got_v, exp_v);
         end
         if (i == 10) begin
            load = 1'b1; digits_in = 16'h5555;
         end
         if (i == 39) begin
            load = 1'b1; digits_in = 16'h6789;
         end
      end
   endtask

   initial begin
      test_reset();
      test_idle_load();
      test_basic_scan();
      test_tear_free();
      test_mask_overwrite();
      test_run_drop_reset();
      test_boundary();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/segment_scan_ctrl.md
# segment_scan_ctrl

Time-multiplexing scan controller for a bank of seven-segment digits sharing one `segment_static` decoder. Holds a double-buffered set of 4-bit digit values, presents one value at a time on the decoder's `data` input, drives a one-hot digit enable, and inserts a blanking gap between digits to prevent ghosting. New display values are loaded through a pulse handshake and take effect only at a frame boundary, so a frame never shows a mix of old and new values.

## Interface
- `N_DIGITS`, 4: number of multiplexed digits (2..8).
- `SCAN_DIV`, 1000: clock cycles per digit SHOW phase (≥1).
- `BLANK_CYC`, 16: clock cycles per digit BLANK phase (≥1).
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `run`  in  1  1 = scanning enabled; 0 = display off.
- `load`  in  1  single-cycle pulse: capture `digits_in` into the shadow buffer.
- `digits_in`  in  4*N_DIGITS  digit values; digit i is `digits_in[4i+3:4i]`.
- `en_mask`  in  N_DIGITS  per-digit enable; 0 keeps that digit dark.
- `data_out`  out  4  value for the shared `segment_static` decoder.
- `dig_en`  out  N_DIGITS  one-hot, active-high digit enable.
- `seg_blank`  out  1  1 = force segments off downstream.
- `load_ack`  out  1  one-cycle pulse when the shadow buffer is committed to the active buffer.
- `frame_done`  out  1  one-cycle pulse at the end of each complete frame.

## Operation
- Storage: `shadow[N_DIGITS]`, `active[N_DIGITS]` (4 bits each), `pending` flag, digit index `idx` (clog2(N_DIGITS) bits), phase counter sized for max(SCAN_DIV, BLANK_CYC).
- FSM states:
  - IDLE: `run`=0.
  - BLANK: counts BLANK_CYC cycles.
  - SHOW: counts SCAN_DIV cycles.
- Transitions:
  - IDLE→BLANK when `run`=1, with `idx`=0 and the counter cleared.
  - BLANK→SHOW after BLANK_CYC cycles.
  - SHOW→BLANK after SCAN_DIV cycles. `idx` increments and wraps from N_DIGITS-1 to 0.
  - Any state→IDLE on the edge where `run`=0: `idx` and the counter are cleared.
- Outputs per state:
  - IDLE: `dig_en`=0, `seg_blank`=1, `data_out`=0.
  - BLANK: `dig_en`=0, `seg_blank`=1, `data_out`=`active[idx]`. The data is presented early so the decoder settles.
  - SHOW: `data_out`=`active[idx]`.
    - If `en_mask[idx]`=1: `dig_en`=1<<`idx`, `seg_blank`=0.
    - Else: `dig_en`=0, `seg_blank`=1. Slot length is unchanged, so brightness stays uniform.
- Load handshake:
  - `load`=1 copies `digits_in` into `shadow` and sets `pending`.
  - A second `load` before commit overwrites `shadow`; the latest value wins and only one `load_ack` is issued.
  - `load` is accepted in every state, including IDLE.
- Commit rule: at the SHOW→BLANK edge with `idx`=N_DIGITS-1 (frame end):
  - `frame_done` pulses.
  - If `pending`: `active`←`shadow`, `pending` clears, and `load_ack` pulses in the same cycle as `frame_done`.
  - If `load` arrives on that same edge: the new value goes into `shadow` and stays pending for the next frame. The commit uses the previous shadow contents.
- While IDLE with `pending`=1: commit happens immediately on the next edge (`load_ack` pulses, no `frame_done`).
- `en_mask` is sampled live every cycle and is not buffered.

## Timing
- Reset (`rst_n`=0 at an edge):
  - State IDLE; `idx`=0; counter=0; `pending`=0.
  - `active`=0 and `shadow`=0.
  - `data_out`=0, `dig_en`=0, `seg_blank`=1, `load_ack`=0, `frame_done`=0.
  - Reset overrides `load` and `run` on the same edge. Reset mid-frame aborts the frame with no `frame_done`.
- All outputs are registered. Each output reflects the state entered at the previous edge.
- Slot = BLANK_CYC+SCAN_DIV cycles. Frame = N_DIGITS×slot cycles.
- First SHOW begins BLANK_CYC+1 edges after `run` rises. `frame_done` is asserted for the cycle following the last SHOW cycle of digit N_DIGITS-1.
- `load` to `load_ack` latency:
  - Scanning: ≤1 frame.
  - IDLE: 1 cycle.
- `dig_en` is never asserted while `seg_blank`=1, and is never multi-hot.

## Test plan
Configuration for all scenarios: N_DIGITS=4, SCAN_DIV=8, BLANK_CYC=2.

1. Reset/idle: hold `rst_n`=0 for 3 cycles, then release with `run`=0 → `dig_en`=0, `seg_blank`=1, `data_out`=0, no pulses for 50 cycles.
2. Basic scan: load `digits_in`=16'h4321 while IDLE → `load_ack` next cycle. Then `run`=1 with mask 4'hF → `dig_en` sequence 0001,0010,0100,1000, each on for 8 cycles after 2 blank cycles, with `data_out` 1,2,3,4. `frame_done` pulses every 40 cycles.
3. Tear-free update: mid-frame during digit 1, load 16'hABCD → `data_out` stays 1..4 for the rest of the frame. `load_ack`+`frame_done` pulse together, then the next frame shows D,C,B,A.
4. Mask/overwrite: `en_mask`=4'b0101 with two loads (16'h1111 then 16'h2222) in one frame → digits 1 and 3 stay dark for full slots. A single `load_ack` is issued, and the following frame shows 2.
5. Run drop and reset mid-frame: `run`=0 during digit 2 → next edge IDLE, `dig_en`=0. `run`=1 restarts at digit 0. Asserting `rst_n`=0 mid-SHOW → all outputs reach reset values next edge, `active`=0, no `frame_done`.
6. Boundary collision: `load` exactly on the frame-end edge → the current commit (if any) uses the old shadow, and the new value is acked at the end of the following frame.
